// File: rtl/fir_decimator_out.sv
// Decimating output stage for the symmetric FIR: keeps one sample in DECIM,
// rounds/saturates to OUT_WIDTH and buffers results in a show-ahead FIFO.
module fir_decimator_out #(
  parameter int IN_WIDTH   = 22,
  parameter int OUT_WIDTH  = 12,
  parameter int SHIFT      = 7,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clear_i,
  input  logic                                 en_i,
  input  logic signed [IN_WIDTH-1:0]           signal_i,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i,
  output logic signed [OUT_WIDTH-1:0]          m_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      level_o,
  output logic                                 sat_o,
  output logic                                 ovf_o
);

  localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic signed [IN_WIDTH:0] ROUND   = (IN_WIDTH+1)'(2 ** (SHIFT - 1));
  localparam logic signed [IN_WIDTH:0] MAX_OUT = (IN_WIDTH+1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [IN_WIDTH:0] MIN_OUT = -MAX_OUT - (IN_WIDTH+1)'(1);

  logic [PHASE_W-1:0]          phase;
  logic                        stage_valid;
  logic signed [OUT_WIDTH-1:0] stage_data;
  logic [OUT_WIDTH-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [PTR_W-1:0]            rd_next;
  logic [LVL_W-1:0]            level;
  logic [LVL_W-1:0]            remaining;

  logic signed [IN_WIDTH:0]    rounded;
  logic signed [IN_WIDTH:0]    shifted;
  logic signed [OUT_WIDTH-1:0] scaled;
  logic                        scaled_sat;
  logic signed [OUT_WIDTH-1:0] head_next;
  logic                        kept;
  logic                        push;
  logic                        pop;

  // One extra bit of headroom so the rounding offset can never wrap.
  always_comb begin
    rounded    = {signal_i[IN_WIDTH-1], signal_i} + ROUND;
    shifted    = rounded >>> SHIFT;
    scaled     = shifted[OUT_WIDTH-1:0];
    scaled_sat = 1'b0;
    if (shifted > MAX_OUT) begin
      scaled     = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      scaled_sat = 1'b1;
    end else if (shifted < MIN_OUT) begin
      scaled     = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      scaled_sat = 1'b1;
    end
  end

  assign kept      = en_i && (phase == '0);
  assign pop       = (level != '0) && m_ready_i;
  assign push      = stage_valid && ((level < LVL_W'(FIFO_DEPTH)) || pop);
  assign rd_next   = rd_ptr + PTR_W'(pop);
  assign remaining = level - LVL_W'(pop);

  // m_data_o is registered: it shows the head as it will be after this edge,
  // and holds its previous value once the FIFO drains.
  always_comb begin
    head_next = m_data_o;
    if (remaining != '0) begin
      head_next = mem[rd_next];
    end else if (push) begin
      head_next = stage_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase       <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      sat_o       <= 1'b0;
      ovf_o       <= 1'b0;
      m_data_o    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (clear_i) begin
      phase       <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      sat_o       <= 1'b0;
      ovf_o       <= 1'b0;
      m_data_o    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (en_i) begin
        phase <= (phase == PHASE_W'(DECIM - 1)) ? '0 : phase + PHASE_W'(1);
      end
      stage_valid <= kept;
      if (kept) begin
        stage_data <= scaled;
      end
      if (kept && scaled_sat) begin
        sat_o <= 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= stage_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (stage_valid && !push) begin
        ovf_o <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      level    <= level + LVL_W'(push) - LVL_W'(pop);
      m_data_o <= head_next;
    end
  end

  assign m_valid_o = (level != '0);
  assign level_o   = level;

endmodule

// File: tb/tb_fir_decimator_out.sv
// Bench for fir_decimator_out: two instances (DECIM=1 and DECIM=4) share stimulus
// and are compared each cycle against a queue-level model, plus directed vectors.
module tb_fir_decimator_out;

  logic clk = 1'b0;
  logic rst;
  logic clear_drv, en_drv, ready_drv;
  logic signed [21:0] sig_drv;

  logic v1, v4, s1, s4, o1, o4;
  logic signed [11:0] d1, d4;
  logic [2:0] l1, l4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fir_decimator_out #(.DECIM(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_drv), .en_i(en_drv), .signal_i(sig_drv),
    .m_valid_o(v1), .m_ready_i(ready_drv), .m_data_o(d1), .level_o(l1),
    .sat_o(s1), .ovf_o(o1));

  fir_decimator_out #(.DECIM(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_drv), .en_i(en_drv), .signal_i(sig_drv),
    .m_valid_o(v4), .m_ready_i(ready_drv), .m_data_o(d4), .level_o(l4),
    .sat_o(s4), .ovf_o(o4));

  // Reference model: per instance a sample counter, one pending kept sample
  // and the FIFO as a plain list whose element 0 is the head.
  int m_phase [2];
  int m_stg_v [2];
  int m_stg_d [2];
  int m_q     [2][4];
  int m_cnt   [2];
  int m_sat   [2];
  int m_ovf   [2];
  int dec_of  [2] = '{1, 4};

  function automatic int scale(input int sig, output bit s);
    int r;
    r = (sig + 64) >>> 7;
    s = 1'b0;
    if (r > 2047) begin s = 1'b1; r = 2047; end
    else if (r < -2048) begin s = 1'b1; r = -2048; end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_stg_v[i] = 0; m_stg_d[i] = 0;
      m_cnt[i] = 0; m_sat[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit pop, acc, s;
    int r;
    if (clear_drv) begin
      m_phase[i] = 0; m_stg_v[i] = 0; m_stg_d[i] = 0;
      m_cnt[i] = 0; m_sat[i] = 0; m_ovf[i] = 0;
      return;
    end
    pop = (m_cnt[i] > 0) && ready_drv;
    acc = (m_stg_v[i] != 0) && ((m_cnt[i] < 4) || pop);
    if (m_stg_v[i] != 0 && !acc) m_ovf[i] = 1;
    if (pop) begin
      for (int j = 0; j < 3; j++) m_q[i][j] = m_q[i][j+1];
      m_cnt[i]--;
    end
    if (acc) begin
      m_q[i][m_cnt[i]] = m_stg_d[i];
      m_cnt[i]++;
    end
    r = scale(int'(sig_drv), s);
    m_stg_v[i] = (en_drv && m_phase[i] == 0) ? 1 : 0;
    if (m_stg_v[i] != 0) begin
      m_stg_d[i] = r;
      if (s) m_sat[i] = 1;
    end
    if (en_drv) m_phase[i] = (m_phase[i] + 1) % dec_of[i];
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input string tag, input int v, input int d,
                            input int l, input int s, input int o);
    check({tag, "_valid"}, v, (m_cnt[i] != 0) ? 1 : 0);
    if (m_cnt[i] != 0) check({tag, "_data"}, d, m_q[i][0]);
    check({tag, "_level"}, l, m_cnt[i]);
    check({tag, "_sat"}, s, m_sat[i]);
    check({tag, "_ovf"}, o, m_ovf[i]);
  endtask

  task automatic checkOutput();
    check_inst(0, "dec1", v1, d1, l1, s1, o1);
    check_inst(1, "dec4", v4, d4, l4, s4, o4);
  endtask

  task automatic applyStimulus(input bit en, input int sig, input bit ready, input bit clr);
    en_drv = en; sig_drv = 22'(sig); ready_drv = ready; clear_drv = clr;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  typedef struct {
    bit en; int sig; bit ready;
    bit ev; int ed; bit esat;
  } vec_t;

  vec_t rows [8];
  int   got [$];

  initial begin
    rows[0] = '{1, 191,      1, 0, 0,     0};
    rows[1] = '{1, 192,      1, 1, 1,     0};
    rows[2] = '{1, -64,      1, 1, 2,     0};
    rows[3] = '{1, -65,      1, 1, 0,     0};
    rows[4] = '{1, 2097151,  1, 1, -1,    1};
    rows[5] = '{1, -2097152, 1, 1, 2047,  1};
    rows[6] = '{0, 0,        1, 1, -2048, 1};
    rows[7] = '{0, 0,        1, 0, 0,     1};

    rst = 1'b1; clear_drv = 0; en_drv = 0; ready_drv = 0; sig_drv = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    check("reset_data", int'(d1), 0);
    rst = 1'b0;

    // Rounding and saturation vectors on the DECIM=1 instance.
    foreach (rows[n]) begin
      applyStimulus(rows[n].en, rows[n].sig, rows[n].ready, 1'b0);
      check("tbl_valid", int'(v1), int'(rows[n].ev));
      if (rows[n].ev) check("tbl_data", int'(d1), rows[n].ed);
      check("tbl_sat", int'(s1), int'(rows[n].esat));
    end
    applyStimulus(0, 0, 1, 1);
    check("clr_sat", int'(s1), 0);

    // Decimation with a pause in en_i.
    got.delete();
    for (int k = 0; k < 22; k++) begin
      if (k < 6)       applyStimulus(1, k * 128, 1, 0);
      else if (k < 9)  applyStimulus(0, 0, 1, 0);
      else if (k < 19) applyStimulus(1, (k - 3) * 128, 1, 0);
      else             applyStimulus(0, 0, 1, 0);
      if (v4) got.push_back(int'(d4));
    end
    check("dec_count", got.size(), 4);
    for (int j = 0; j < 4; j++)
      if (j < got.size()) check("dec_data", got[j], 4 * j);

    // Backpressure with overflow, then drain.
    applyStimulus(0, 0, 0, 1);
    for (int k = 1; k <= 6; k++) applyStimulus(1, k * 128, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    check("bp_level", int'(l1), 4);
    check("bp_ovf", int'(o1), 1);
    got.delete();
    for (int k = 0; k < 6; k++) begin
      if (v1) got.push_back(int'(d1));
      applyStimulus(0, 0, 1, 0);
    end
    check("bp_count", got.size(), 4);
    for (int j = 0; j < 4; j++)
      if (j < got.size()) check("bp_data", got[j], j + 1);

    // Full FIFO with push and pop on the same edge.
    applyStimulus(0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) applyStimulus(1, k * 128, 0, 0);
    applyStimulus(0, 0, 0, 0);
    check("full_level", int'(l1), 4);
    applyStimulus(1, 5 * 128, 0, 0);
    applyStimulus(0, 0, 1, 0);
    check("fullpop_level", int'(l1), 4);
    check("fullpop_ovf", int'(o1), 0);
    check("fullpop_head", int'(d1), 2);

    // Synchronous clear with level 3 and a sample in the stage register.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 2097151, 0, 0);
    for (int k = 2; k <= 4; k++) applyStimulus(1, k * 128, 0, 0);
    check("preclr_level", int'(l1), 3);
    check("preclr_sat", int'(s1), 1);
    applyStimulus(0, 0, 0, 1);
    check("clr_level", int'(l1), 0);
    check("clr_valid", int'(v1), 0);
    check("clr_flag", int'(s1), 0);

    // Asynchronous reset pulse between edges.
    applyStimulus(1, 2097151, 0, 0);
    for (int k = 2; k <= 4; k++) applyStimulus(1, k * 128, 0, 0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("arst_level", int'(l1), 0);
    check("arst_valid", int'(v1), 0);
    check("arst_sat", int'(s1), 0);
    checkOutput();
    #1 rst = 1'b0;
    applyStimulus(1, 9 * 128, 1, 0);
    applyStimulus(0, 0, 1, 0);
    check("arst_first1", int'(d1), 9);
    check("arst_first4", int'(d4), 9);
    check("arst_valid4", int'(v4), 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int sig;
      case ($urandom_range(5, 0))
        0:       sig = 2097151;
        1:       sig = -2097152;
        2:       sig = int'($urandom_range(512, 0)) - 256;
        default: sig = int'($urandom_range(4194303, 0)) - 2097152;
      endcase
      applyStimulus(($urandom_range(3, 0) != 0), sig, ($urandom_range(2, 0) != 0),
                    ($urandom_range(63, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
